// File: rtl/mem_stage_if.sv
// mem_stage_if: single-outstanding request/ready data-memory port.
// The master (the MEM stage) holds dmem_req with stable fields until dmem_ready.
interface mem_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_rdata;
  logic        dmem_ready;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    input  dmem_rdata, dmem_ready
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    output dmem_rdata, dmem_ready
  );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: RV32I MEM pipeline stage. Issues byte/half/word loads and stores
// over a single-outstanding data-memory port, stalls the pipeline while the
// access is in flight, and aligns/extends load data for WB.
// Optional feature macro: MEM_MISALIGN_TRAP_EN
//   defined   -> misaligned half/word accesses are suppressed and flagged
//   undefined -> low address bits are forced to natural alignment
module mem_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  mem_stage_if.master dmem,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        misaligned,
  output logic        bus_error
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Last BUSY cycle index before the access is abandoned
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 32'd1);

  state_t      state_r;
  logic        req_r;
  logic        we_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic [3:0]  wstrb_r;
  logic [2:0]  f3_r;
  logic [1:0]  off_r;
  logic [15:0] cnt_r;
  logic [31:0] load_data_r;
  logic        load_valid_r;
  logic        bus_error_r;

  logic        access_s;
  logic        trap_s;
  logic [1:0]  off_s;
  logic [3:0]  wstrb_s;
  logic [31:0] wdata_s;

  // Move the addressed lane down to bit 0, then sign- or zero-extend by size
  function automatic logic [31:0] extend_load(input logic [31:0] rdata,
                                              input logic [1:0]  off,
                                              input logic [2:0]  f3);
    logic [31:0] sh;
    sh = rdata >> {off, 3'b000};
    case (f3)
      3'b000:  extend_load = {{24{sh[7]}}, sh[7:0]};
      3'b001:  extend_load = {{16{sh[15]}}, sh[15:0]};
      3'b100:  extend_load = {24'h000000, sh[7:0]};
      3'b101:  extend_load = {16'h0000, sh[15:0]};
      default: extend_load = sh;
    endcase
  endfunction

  // Decode access size: aligned byte offset, write lanes and replicated store data
  always_comb begin
    access_s = mem_valid & (mem_read | mem_write);
    off_s    = alu_result[1:0];
    wstrb_s  = 4'b0000;
    wdata_s  = 32'h0000_0000;
    trap_s   = 1'b0;
    case (funct3[1:0])
      2'b00: begin
        wstrb_s = 4'b0001 << off_s;
        wdata_s = {4{store_data[7:0]}};
      end
      2'b01: begin
        off_s   = {alu_result[1], 1'b0};
        wstrb_s = 4'b0011 << off_s;
        wdata_s = {2{store_data[15:0]}};
      end
      default: begin
        off_s   = 2'b00;
        wstrb_s = 4'b1111;
        wdata_s = store_data;
      end
    endcase
`ifdef MEM_MISALIGN_TRAP_EN
    case (funct3[1:0])
      2'b00:   trap_s = 1'b0;
      2'b01:   trap_s = alu_result[0];
      default: trap_s = (alu_result[1:0] != 2'b00);
    endcase
`endif
  end

  // Freeze the pipeline from the cycle an access is seen until it completes
  always_comb begin
    stall      = 1'b0;
    misaligned = 1'b0;
    case (state_r)
      IDLE: begin
        stall      = access_s & ~trap_s;
        misaligned = access_s & trap_s;
      end
      BUSY: begin
        stall      = 1'b1;
        misaligned = 1'b0;
      end
      default: begin
        stall      = 1'b0;
        misaligned = 1'b0;
      end
    endcase
  end

  // Walk each access through IDLE/BUSY/DONE and register bus and WB outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      req_r        <= 1'b0;
      we_r         <= 1'b0;
      addr_r       <= 32'h0000_0000;
      wdata_r      <= 32'h0000_0000;
      wstrb_r      <= 4'b0000;
      f3_r         <= 3'b000;
      off_r        <= 2'b00;
      cnt_r        <= 16'd0;
      load_data_r  <= 32'h0000_0000;
      load_valid_r <= 1'b0;
      bus_error_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          load_valid_r <= 1'b0;
          bus_error_r  <= 1'b0;
          cnt_r        <= 16'd0;
          if (access_s && !trap_s) begin
            state_r <= BUSY;
            req_r   <= 1'b1;
            we_r    <= mem_write;
            addr_r  <= {alu_result[31:2], 2'b00};
            wdata_r <= mem_write ? wdata_s : 32'h0000_0000;
            wstrb_r <= mem_write ? wstrb_s : 4'b0000;
            f3_r    <= funct3;
            off_r   <= off_s;
          end else begin
            state_r <= IDLE;
            req_r   <= 1'b0;
          end
        end
        BUSY: begin
          if (dmem.dmem_ready) begin
            state_r <= DONE;
            req_r   <= 1'b0;
            if (!we_r) begin
              load_data_r  <= extend_load(dmem.dmem_rdata, off_r, f3_r);
              load_valid_r <= 1'b1;
            end else begin
              load_valid_r <= 1'b0;
            end
          end else if (cnt_r == TIMEOUT_LAST) begin
            // Ready on the limit cycle is handled above, so it wins over abort
            state_r     <= DONE;
            req_r       <= 1'b0;
            bus_error_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
        DONE: begin
          // Pipeline advances this cycle, so IDLE next sees a new instruction
          state_r      <= IDLE;
          load_valid_r <= 1'b0;
          bus_error_r  <= 1'b0;
          cnt_r        <= 16'd0;
        end
        default: begin
          state_r      <= IDLE;
          req_r        <= 1'b0;
          load_valid_r <= 1'b0;
          bus_error_r  <= 1'b0;
        end
      endcase
    end
  end

  assign dmem.dmem_req   = req_r;
  assign dmem.dmem_we    = we_r;
  assign dmem.dmem_addr  = addr_r;
  assign dmem.dmem_wdata = wdata_r;
  assign dmem.dmem_wstrb = wstrb_r;
  assign load_data       = load_data_r;
  assign load_valid      = load_valid_r;
  assign bus_error       = bus_error_r;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed bench for mem_stage with a transaction-level model
// (byte-addressed memory, per-access timeline) and a per-cycle compare process.
`timescale 1ns/1ps
module tb_mem_stage;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] alu_result, store_data;
  logic        stall, load_valid, misaligned, bus_error;
  logic [31:0] load_data;

  mem_stage_if dmem_bus();

  mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_valid  (mem_valid),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .funct3     (funct3),
    .alu_result (alu_result),
    .store_data (store_data),
    .dmem       (dmem_bus),
    .stall      (stall),
    .load_data  (load_data),
    .load_valid (load_valid),
    .misaligned (misaligned),
    .bus_error  (bus_error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Expected per-cycle outputs, set by the stimulus from the transaction model
  bit          chk_en = 1'b0;
  logic        exp_stall = 1'b0, exp_req = 1'b0, exp_we = 1'b0;
  logic        exp_lv = 1'b0, exp_mis = 1'b0, exp_be = 1'b0;
  logic [31:0] exp_addr = 32'h0, exp_wdata = 32'h0, exp_load = 32'h0;
  logic [3:0]  exp_strb = 4'h0;

  // Observation counters and last-seen values
  int          stall_cnt = 0, req_cnt = 0, lv_cnt = 0, be_cnt = 0, mis_cnt = 0;
  logic [31:0] seen_addr = 32'h0, seen_wdata = 32'h0, seen_load = 32'h0;
  logic [3:0]  seen_strb = 4'h0;

  // Backing store of the memory model, indexed by word number
  logic [31:0] mem [int unsigned];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] memrd(input logic [31:0] a);
    int unsigned k;
    k = a >> 2;
    if (mem.exists(k)) return mem[k];
    return 32'h0;
  endfunction

  task automatic memwr(input logic [31:0] a, input logic [3:0] strb, input logic [31:0] wd);
    logic [31:0] w;
    w = memrd(a);
    for (int b = 0; b < 4; b++)
      if (strb[b]) w[8*b +: 8] = wd[8*b +: 8];
    mem[a >> 2] = w;
  endtask

  // Effective byte offset after natural alignment of halves and words
  function automatic int unsigned eff_off(input logic [2:0] f3, input logic [31:0] a);
    case (f3[1:0])
      2'b00:   return a % 4;
      2'b01:   return (a % 4) & 2;
      default: return 0;
    endcase
  endfunction

  function automatic logic [3:0] ref_strb(input logic [2:0] f3, input logic [31:0] a, input bit wr);
    if (!wr) return 4'h0;
    case (f3[1:0])
      2'b00:   return 4'(1 << eff_off(f3, a));
      2'b01:   return 4'(3 << eff_off(f3, a));
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   return (d & 32'hFF) * 32'h0101_0101;
      2'b01:   return (d & 32'hFFFF) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] v;
    v = word >> (8 * eff_off(f3, a));
    case (f3)
      3'b000: begin v = v & 32'hFF;   if (v >= 32'h80)   v = v - 32'h100;   end
      3'b001: begin v = v & 32'hFFFF; if (v >= 32'h8000) v = v - 32'h10000; end
      3'b100: v = v & 32'hFF;
      3'b101: v = v & 32'hFFFF;
      default: v = word;
    endcase
    return v;
  endfunction

  function automatic bit ref_trap(input logic [2:0] f3, input logic [31:0] a);
`ifdef MEM_MISALIGN_TRAP_EN
    case (f3[1:0])
      2'b00:   return 1'b0;
      2'b01:   return a[0];
      default: return a[1:0] != 2'b00;
    endcase
`else
    return 1'b0;
`endif
  endfunction

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall", 32'(stall), 32'(exp_stall));
      chk("dmem_req", 32'(dmem_bus.dmem_req), 32'(exp_req));
      chk("load_valid", 32'(load_valid), 32'(exp_lv));
      chk("misaligned", 32'(misaligned), 32'(exp_mis));
      chk("bus_error", 32'(bus_error), 32'(exp_be));
      if (exp_req) begin
        chk("dmem_addr", dmem_bus.dmem_addr, exp_addr);
        chk("dmem_we", 32'(dmem_bus.dmem_we), 32'(exp_we));
        chk("dmem_wstrb", 32'(dmem_bus.dmem_wstrb), 32'(exp_strb));
        if (exp_we) chk("dmem_wdata", dmem_bus.dmem_wdata, exp_wdata);
      end
      if (exp_lv) chk("load_data", load_data, exp_load);
    end
    if (stall) stall_cnt++;
    if (dmem_bus.dmem_req) begin
      req_cnt++;
      seen_addr  = dmem_bus.dmem_addr;
      seen_strb  = dmem_bus.dmem_wstrb;
      seen_wdata = dmem_bus.dmem_wdata;
    end
    if (load_valid) begin lv_cnt++; seen_load = load_data; end
    if (bus_error) be_cnt++;
    if (misaligned) mis_cnt++;
  end

  task automatic clr();
    stall_cnt = 0; req_cnt = 0; lv_cnt = 0; be_cnt = 0; mis_cnt = 0;
    seen_load = 32'h0;
  endtask

  task automatic exp_idle();
    exp_stall = 1'b0; exp_req = 1'b0; exp_lv = 1'b0; exp_mis = 1'b0; exp_be = 1'b0;
  endtask

  task automatic idle(input int n, input bit nonmem);
    mem_valid = nonmem; mem_read = 1'b0; mem_write = 1'b0;
    dmem_bus.dmem_ready = 1'b1;
    dmem_bus.dmem_rdata = $urandom;
    exp_idle();
    repeat (n) begin @(posedge clk); #1; end
    dmem_bus.dmem_ready = 1'b0;
  endtask

  // One instruction through the stage: detect, BUSY cycles, DONE
  task automatic access(input bit rd, input bit wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d, input int waits);
    bit trap, done;
    trap = ref_trap(f3, a);
    mem_valid = 1'b1; mem_read = rd; mem_write = wr;
    funct3 = f3; alu_result = a; store_data = d;
    dmem_bus.dmem_ready = 1'b1;      // ready while not BUSY must be ignored
    dmem_bus.dmem_rdata = $urandom;
    exp_idle();
    exp_stall = !trap; exp_mis = trap;
    exp_addr  = {a[31:2], 2'b00};
    exp_we    = wr;
    exp_strb  = ref_strb(f3, a, wr);
    exp_wdata = ref_wdata(f3, d);
    @(posedge clk); #1;
    if (trap) begin
      exp_idle();
      dmem_bus.dmem_ready = 1'b0;
      return;
    end
    exp_stall = 1'b1; exp_req = 1'b1; exp_mis = 1'b0;
    done = 1'b0;
    for (int i = 0; i < TO; i++) begin
      if (i == waits) begin
        dmem_bus.dmem_ready = 1'b1;
        dmem_bus.dmem_rdata = memrd(a);
        done = 1'b1;
      end else begin
        dmem_bus.dmem_ready = 1'b0;
        dmem_bus.dmem_rdata = $urandom;
      end
      @(posedge clk); #1;
      if (done) break;
    end
    dmem_bus.dmem_ready = 1'b0;
    dmem_bus.dmem_rdata = $urandom;
    exp_stall = 1'b0; exp_req = 1'b0;
    exp_be    = !done;
    exp_lv    = done && !wr;
    exp_load  = ref_load(memrd(a), f3, a);
    if (done && wr) memwr(a, exp_strb, exp_wdata);
    @(posedge clk); #1;
    exp_lv = 1'b0; exp_be = 1'b0;
  endtask

  initial begin
    rst = 1'b1; mem_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    funct3 = 3'b000; alu_result = 32'h0; store_data = 32'h0;
    dmem_bus.dmem_ready = 1'b0; dmem_bus.dmem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", 32'(dmem_bus.dmem_req), 32'd0);
    chk("rst_we", 32'(dmem_bus.dmem_we), 32'd0);
    chk("rst_addr", dmem_bus.dmem_addr, 32'd0);
    chk("rst_wdata", dmem_bus.dmem_wdata, 32'd0);
    chk("rst_wstrb", 32'(dmem_bus.dmem_wstrb), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_load_data", load_data, 32'd0);
    chk("rst_load_valid", 32'(load_valid), 32'd0);
    chk("rst_misaligned", 32'(misaligned), 32'd0);
    chk("rst_bus_error", 32'(bus_error), 32'd0);
    rst = 1'b0;
    exp_idle();
    chk_en = 1'b1;

    idle(2, 1'b0);
    idle(2, 1'b1);                      // non-memory instruction, ready toggling

    clr(); access(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 0);
    chk("sw_stall_cycles", 32'(stall_cnt), 32'd2);
    chk("sw_req_cycles", 32'(req_cnt), 32'd1);
    chk("sw_addr", seen_addr, 32'h100);
    chk("sw_strb", 32'(seen_strb), 32'hF);
    chk("sw_wdata", seen_wdata, 32'hDEADBEEF);

    access(1'b0, 1'b1, 3'b010, 32'h200, 32'h80FF7F01, 1);
    clr(); access(1'b1, 1'b0, 3'b000, 32'h203, 32'h0, 0);
    chk("lb_203", seen_load, 32'hFFFFFF80);
    clr(); access(1'b1, 1'b0, 3'b100, 32'h203, 32'h0, 2);
    chk("lbu_203", seen_load, 32'h00000080);
    clr(); access(1'b1, 1'b0, 3'b001, 32'h202, 32'h0, 0);
    chk("lh_202", seen_load, 32'hFFFF80FF);
    clr(); access(1'b1, 1'b0, 3'b101, 32'h200, 32'h0, 1);
    chk("lhu_200", seen_load, 32'h00007F01);

    clr(); access(1'b0, 1'b1, 3'b000, 32'h105, 32'h000000AB, 2);
    chk("sb_addr", seen_addr, 32'h104);
    chk("sb_strb", 32'(seen_strb), 32'h2);
    chk("sb_wdata", seen_wdata, 32'hABABABAB);
    clr(); access(1'b0, 1'b1, 3'b001, 32'h10A, 32'h00001234, 0);
    chk("sh_strb", 32'(seen_strb), 32'hC);
    chk("sh_wdata", seen_wdata, 32'h12341234);
    clr(); access(1'b1, 1'b0, 3'b010, 32'h104, 32'h0, 0);
    chk("lw_104", seen_load, 32'h0000AB00);
    clr(); access(1'b1, 1'b0, 3'b010, 32'h108, 32'h0, 0);
    chk("lw_108", seen_load, 32'h12340000);

    clr(); access(1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 3);
    chk("lw_wait3_stall", 32'(stall_cnt), 32'd5);
    chk("lw_wait3_lv", 32'(lv_cnt), 32'd1);
    chk("lw_wait3_data", seen_load, 32'h80FF7F01);
    chk("lw_wait3_be", 32'(be_cnt), 32'd0);

    clr(); access(1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 100);
    chk("to_bus_error", 32'(be_cnt), 32'd1);
    chk("to_req_cycles", 32'(req_cnt), 32'd4);
    chk("to_stall", 32'(stall_cnt), 32'd5);
    chk("to_lv", 32'(lv_cnt), 32'd0);

    clr(); access(1'b1, 1'b1, 3'b010, 32'h120, 32'h0BADF00D, 0);
    chk("rw_lv", 32'(lv_cnt), 32'd0);
    clr(); access(1'b1, 1'b0, 3'b010, 32'h120, 32'h0, 0);
    chk("rw_readback", seen_load, 32'h0BADF00D);

    clr(); access(1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 0);
`ifdef MEM_MISALIGN_TRAP_EN
    chk("mis_pulse", 32'(mis_cnt), 32'd1);
    chk("mis_no_req", 32'(req_cnt), 32'd0);
    chk("mis_no_stall", 32'(stall_cnt), 32'd0);
`else
    chk("mis_addr", seen_addr, 32'h100);
    chk("mis_req", 32'(req_cnt), 32'd1);
    chk("mis_data", seen_load, 32'hDEADBEEF);
    clr(); access(1'b1, 1'b0, 3'b001, 32'h203, 32'h0, 0);
    chk("mis_lh_203", seen_load, 32'hFFFF80FF);
`endif
    idle(1, 1'b0);

    // Reset while BUSY: request drops after the reset edge, no completion
    clr();
    mem_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0;
    funct3 = 3'b010; alu_result = 32'h300;
    exp_idle(); exp_stall = 1'b1;
    @(posedge clk); #1;
    exp_req = 1'b1; exp_addr = 32'h300; exp_we = 1'b0; exp_strb = 4'h0;
    @(posedge clk); #1;
    rst = 1'b1; mem_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_idle();
    @(posedge clk); #1;
    chk("rst_busy_req", 32'(dmem_bus.dmem_req), 32'd0);
    chk("rst_busy_lv", 32'(lv_cnt), 32'd0);
    chk("rst_busy_be", 32'(be_cnt), 32'd0);

    clr(); access(1'b1, 1'b0, 3'b100, 32'h201, 32'h0, 0);
    chk("post_rst_lbu", seen_load, 32'h0000007F);
    idle(2, 1'b0);
    chk_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
